i2c_slave_bit_shift: RTL and testbench

Byte-level I2C target (slave) engine: the responder end of the bus driven by the team's I2C master bit-shift engine. It detects START/repeated-START/STOP, matches a 7-bit address, ACKs, and then either delivers written bytes to user logic or transmits bytes fetched from user logic. It sits between the open-drain I2C pins and a register-file/FIFO front end. It never drives SCL, so there is no clock stretching.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_sync.sv | 56 +++++
 rtl/i2c_slave_bit_shift.sv | 197 +++++++++++++++++++
 tb/tb_i2c_slave_bit_shift.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C constants: one-hot target FSM states, ACK/NACK levels, datapath widths.
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [7:0] {
        IDLE      = 8'b0000_0001,
        ADDR      = 8'b0000_0010,
        ADDR_ACK  = 8'b0000_0100,
        WR_DATA   = 8'b0000_1000,
        WR_ACK    = 8'b0001_0000,
        RD_DATA   = 8'b0010_0000,
        RD_ACK    = 8'b0100_0000,
        WAIT_STOP = 8'b1000_0000
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes one I2C line and reports its level and edges.
// Optional 3-sample glitch filter when I2C_SLV_GLITCH_FILTER_EN is defined.
module i2c_line_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic line,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [1:0] sync_q;

    // Idle bus lines are high, so reset to 1 to avoid a false edge after reset
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], line};
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    logic       filt_d;

    always_comb begin
        filt_d = filt_q;
        if ((sync_q[1] == hist_q[0]) && (sync_q[1] == hist_q[1])) filt_d = sync_q[1];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
            filt_q <= filt_d;
        end
    end

    assign level  = filt_q;
    assign rise_c = filt_d & ~filt_q;
    assign fall_c = ~filt_d & filt_q;
`else
    logic prev_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) prev_q <= 1'b1;
        else     prev_q <= sync_q[1];
    end

    assign level  = sync_q[1];
    assign rise_c = sync_q[1] & ~prev_q;
    assign fall_c = ~sync_q[1] & prev_q;
`endif

endmodule

// File: rtl/i2c_slave_bit_shift.sv
// Byte-level I2C target: address match, ACK generation, write delivery and read fetch.
// Build option: I2C_SLV_GLITCH_FILTER_EN enables the line glitch filters.
module i2c_slave_bit_shift
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i2c_sclk,
    inout  wire               i2c_sdat,
    output logic [BYTE_W-1:0] Rx_DATA,
    output logic              Rx_Valid,
    input  logic [BYTE_W-1:0] Tx_DATA,
    output logic              Tx_Req,
    output logic              Addr_Match,
    output logic              Rw,
    output logic              Mst_Ack,
    output logic              Stop_Det,
    output logic              Busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .Clk    (Clk),
        .Rst    (Rst),
        .line   (i2c_sclk),
        .level  (scl_lvl),
        .rise_c (scl_rise),
        .fall_c (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .Clk    (Clk),
        .Rst    (Rst),
        .line   (i2c_sdat),
        .level  (sda_lvl),
        .rise_c (sda_rise),
        .fall_c (sda_fall)
    );

    i2c_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              ack_drv_q, ack_drv_d;
    logic              rd_en_q, rd_en_d;
    logic [BYTE_W-1:0] rx_data_d;
    logic              rx_valid_d, tx_req_d, addr_match_d, rw_d, mst_ack_d, stop_det_d, busy_d;
    logic              start_c, stop_c, sda_low_c;

    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;

    // Bit 7 of a read byte goes out in the Tx_Req cycle itself, straight from Tx_DATA
    assign sda_low_c = (ack_drv_q | (rd_en_q & ~shift_q[7]) | (Tx_Req & ~Tx_DATA[7])) & ~Rst;
    assign i2c_sdat  = sda_low_c ? 1'b0 : 1'bz;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        ack_drv_d    = ack_drv_q;
        rd_en_d      = rd_en_q;
        rx_data_d    = Rx_DATA;
        rx_valid_d   = 1'b0;
        tx_req_d     = 1'b0;
        addr_match_d = 1'b0;
        rw_d         = Rw;
        mst_ack_d    = Mst_Ack;
        stop_det_d   = 1'b0;
        busy_d       = Busy;

        if (Tx_Req) begin
            shift_d = Tx_DATA;
            rd_en_d = 1'b1;
        end

        case (state_q)
            IDLE: ;
            ADDR: begin
                if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_lvl};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        if (shift_q[6:0] == SLAVE_ADDR) begin
                            addr_match_d = 1'b1;
                            rw_d         = sda_lvl;
                            busy_d       = 1'b1;
                            state_d      = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
            end
            // First fall asserts the ACK, the second fall ends the ACK slot
            ADDR_ACK, WR_ACK: begin
                if (scl_fall) begin
                    if (!ack_drv_q) begin
                        ack_drv_d = 1'b1;
                    end else begin
                        ack_drv_d = 1'b0;
                        if ((state_q == WR_ACK) || !Rw) begin
                            state_d = WR_DATA;
                        end else begin
                            tx_req_d = 1'b1;
                            state_d  = RD_DATA;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_lvl};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        rx_data_d  = {shift_q[6:0], sda_lvl};
                        rx_valid_d = 1'b1;
                        state_d    = WR_ACK;
                    end
                end
            end
            RD_DATA: begin
                if (scl_fall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        rd_en_d = 1'b0;
                        state_d = RD_ACK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            RD_ACK: begin
                if (scl_rise) mst_ack_d = sda_lvl;
                if (scl_fall) begin
                    if (Mst_Ack == I2C_ACK) begin
                        tx_req_d = 1'b1;
                        state_d  = RD_DATA;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
            end
            WAIT_STOP: ;
            default: state_d = IDLE;
        endcase

        // Bus conditions override any bit event seen in the same cycle
        if (start_c || stop_c) begin
            state_d      = start_c ? ADDR : IDLE;
            cnt_d        = '0;
            ack_drv_d    = 1'b0;
            rd_en_d      = 1'b0;
            busy_d       = 1'b0;
            rx_valid_d   = 1'b0;
            tx_req_d     = 1'b0;
            addr_match_d = 1'b0;
            stop_det_d   = stop_c;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            ack_drv_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            Rx_DATA    <= '0;
            Rx_Valid   <= 1'b0;
            Tx_Req     <= 1'b0;
            Addr_Match <= 1'b0;
            Rw         <= 1'b0;
            Mst_Ack    <= I2C_NACK;
            Stop_Det   <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ack_drv_q  <= ack_drv_d;
            rd_en_q    <= rd_en_d;
            Rx_DATA    <= rx_data_d;
            Rx_Valid   <= rx_valid_d;
            Tx_Req     <= tx_req_d;
            Addr_Match <= addr_match_d;
            Rw         <= rw_d;
            Mst_Ack    <= mst_ack_d;
            Stop_Det   <= stop_det_d;
            Busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_bit_shift.sv
// Bench for i2c_slave_bit_shift: bit-banged bus master, event scoreboard and bus-level checks.
module tb_i2c_slave_bit_shift;

    localparam int unsigned Q = 10;
    localparam logic [6:0]  MY_ADDR = 7'h50;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       m_scl;
    logic       m_sda_low;
    logic [7:0] Tx_DATA;
    logic [7:0] Rx_DATA;
    logic       Rx_Valid, Tx_Req, Addr_Match, Rw, Mst_Ack, Stop_Det, Busy;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 Clk = ~Clk;

    i2c_slave_bit_shift dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .i2c_sclk   (m_scl),
        .i2c_sdat   (sda_bus),
        .Rx_DATA    (Rx_DATA),
        .Rx_Valid   (Rx_Valid),
        .Tx_DATA    (Tx_DATA),
        .Tx_Req     (Tx_Req),
        .Addr_Match (Addr_Match),
        .Rw         (Rw),
        .Mst_Ack    (Mst_Ack),
        .Stop_Det   (Stop_Det),
        .Busy       (Busy)
    );

    typedef enum int {EV_ADDR = 1, EV_RX = 2, EV_TXREQ = 3, EV_STOP = 4} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic mon_event(input ev_kind_e kind, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h required none", kind, data);
        end else begin
            e = exp_q.pop_front();
            check("event", {16'(kind), 8'h00, data}, {16'(e.kind), 8'h00, e.data});
        end
    endtask

    // Monitor: every DUT pulse pops one expected event
    always @(negedge Clk) begin
        if (!Rst) begin
            if ((32'(Addr_Match) + 32'(Rx_Valid) + 32'(Tx_Req) + 32'(Stop_Det)) > 32'd1)
                check("pulse_overlap", {Addr_Match, Rx_Valid, Tx_Req, Stop_Det}, 32'd0);
            if (Addr_Match) mon_event(EV_ADDR, {7'd0, Rw});
            if (Rx_Valid)   mon_event(EV_RX, Rx_DATA);
            if (Tx_Req)     mon_event(EV_TXREQ, 8'h00);
            if (Stop_Det)   mon_event(EV_STOP, 8'h00);
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge Clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; wait_q();
        m_scl     = 1'b1; wait_q();
        m_sda_low = 1'b1; wait_q();
        m_scl     = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q();
        m_scl     = 1'b1; wait_q();
        m_sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_sda_low = ~b; wait_q();
        m_scl     = 1'b1; wait_q();
        s         = sda_bus; wait_q();
        m_scl     = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    // Reference model: a matching address ACKs everything and reports each byte once
    task automatic xfer_write(input logic [6:0] a, input logic [7:0] data[$], input bit do_stop);
        logic ack;
        bit   match;
        match = (a == MY_ADDR);
        if (match) exp_q.push_back('{EV_ADDR, 8'h00});
        bus_start();
        write_byte({a, 1'b0}, ack);
        check("addr_ack_w", 32'(ack), match ? 32'd0 : 32'd1);
        check("busy_after_addr_w", 32'(Busy), 32'(match));
        foreach (data[i]) begin
            if (match) exp_q.push_back('{EV_RX, data[i]});
            write_byte(data[i], ack);
            check("data_ack_w", 32'(ack), match ? 32'd0 : 32'd1);
        end
        if (do_stop) begin
            exp_q.push_back('{EV_STOP, 8'h00});
            bus_stop();
            check("busy_after_stop", 32'(Busy), 32'd0);
        end
    endtask

    // Matched read: the last byte is NACKed, every other byte ACKed
    task automatic xfer_read(input logic [7:0] data[$]);
        logic       ack, s;
        logic [7:0] got;
        exp_q.push_back('{EV_ADDR, 8'h01});
        exp_q.push_back('{EV_TXREQ, 8'h00});
        Tx_DATA = data[0];
        bus_start();
        write_byte({MY_ADDR, 1'b1}, ack);
        check("addr_ack_r", 32'(ack), 32'd0);
        check("busy_after_addr_r", 32'(Busy), 32'd1);
        for (int i = 0; i < data.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                bus_bit(1'b1, s);
                got[b] = s;
            end
            check("read_byte", 32'(got), 32'(data[i]));
            if (i + 1 < data.size()) begin
                Tx_DATA = data[i+1];
                exp_q.push_back('{EV_TXREQ, 8'h00});
                bus_bit(1'b0, s);
                check("mst_ack_ack", 32'(Mst_Ack), 32'd0);
            end else begin
                bus_bit(1'b1, s);
                check("mst_ack_nack", 32'(Mst_Ack), 32'd1);
                wait_q();
                check("sda_released_after_nack", 32'(sda_bus), 32'd1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"}, 32'(Rx_DATA), 32'd0);
        check({tag, "_pulses"}, {Rx_Valid, Tx_Req, Addr_Match, Stop_Det}, 32'd0);
        check({tag, "_rw"}, 32'(Rw), 32'd0);
        check({tag, "_mst_ack"}, 32'(Mst_Ack), 32'd1);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_sda"}, 32'(sda_bus), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic       s;

        Rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0; Tx_DATA = 8'h00;
        repeat (5) @(negedge Clk);
        check_reset_outputs("reset_hold");
        Rst = 1'b0;
        repeat (5) @(negedge Clk);
        check_reset_outputs("reset_idle");

        q = '{8'hA5};
        xfer_write(MY_ADDR, q, 1'b1);
        check("rx_data_a5", 32'(Rx_DATA), 32'hA5);

        q = '{8'h11};
        xfer_write(7'h51, q, 1'b1);
        check("rx_data_kept", 32'(Rx_DATA), 32'hA5);

        q = '{8'h3C, 8'hC3};
        xfer_read(q);
        exp_q.push_back('{EV_STOP, 8'h00});
        bus_stop();
        check("busy_after_read_stop", 32'(Busy), 32'd0);

        q = '{8'h01};
        xfer_write(MY_ADDR, q, 1'b0);
        q = '{8'h7E};
        xfer_read(q);
        exp_q.push_back('{EV_STOP, 8'h00});
        bus_stop();
        check("rx_data_01", 32'(Rx_DATA), 32'h01);
        check("rw_read", 32'(Rw), 32'd1);

        for (int t = 0; t < 6; t++) begin
            logic [6:0] a;
            int         n;
            a = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : MY_ADDR;
            n = $urandom_range(1, 3);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                xfer_write(a, q, 1'b1);
                if (a == MY_ADDR) check("rand_rx_last", 32'(Rx_DATA), 32'(q[n-1]));
            end else begin
                xfer_read(q);
                exp_q.push_back('{EV_STOP, 8'h00});
                bus_stop();
            end
        end

        // Reset in the middle of a read byte of zeros, while the target holds SDA low
        exp_q.push_back('{EV_ADDR, 8'h01});
        exp_q.push_back('{EV_TXREQ, 8'h00});
        Tx_DATA = 8'h00;
        bus_start();
        write_byte({MY_ADDR, 1'b1}, s);
        for (int b = 0; b < 3; b++) bus_bit(1'b1, s);
        m_sda_low = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        check("sda_low_before_reset", 32'(sda_bus), 32'd0);
        #2 Rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        m_scl = 1'b0; wait_q();
        exp_q.push_back('{EV_STOP, 8'h00});
        bus_stop();
        q = '{8'h5A, 8'h96};
        xfer_write(MY_ADDR, q, 1'b1);
        check("post_reset_rx", 32'(Rx_DATA), 32'h96);

        // One-cycle SDA low glitch with SCL high on an idle bus
`ifndef I2C_SLV_GLITCH_FILTER_EN
        exp_q.push_back('{EV_STOP, 8'h00});
`endif
        m_sda_low = 1'b1;
        @(negedge Clk);
        m_sda_low = 1'b0;
        repeat (20) @(negedge Clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
